// File: rtl/mandel_pkg.sv
// Shared types and sizing helpers for the Mandelbrot frame scheduler.
// Coordinates are Q4.12 two's-complement; all sizes derive from frame/engine counts.
package mandel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam int          Q_FRAC_BITS = 12;
  localparam logic [15:0] Q_ONE       = 16'h1000;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_w(input int h, input int v);
    return cnt_w(h * v);
  endfunction

  function automatic int eng_w(input int n);
    return cnt_w(n);
  endfunction

endpackage

// File: rtl/mandel_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from a rotating pointer.
// The pointer moves to one past the winner on every grant.
module mandel_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_vld
);

  logic [W-1:0] ptr;
  int           k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    k         = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!grant_vld && req[k]) begin
        grant[k]  = 1'b1;
        grant_idx = W'(k);
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
    end
  end

endmodule

// File: rtl/mandel_frame_scheduler.sv
// Walks an H x V frame issuing one registered job per cycle to the lowest idle engine,
// and round-robins engine results onto the framebuffer port one cycle after the ack.
module mandel_frame_scheduler
  import mandel_pkg::*;
#(
  parameter  int H_ACTIVE    = 64,
  parameter  int V_ACTIVE    = 48,
  parameter  int NUM_ENGINES = 4,
  parameter  int COORD_W     = 16,
  parameter  int ITER_W      = 8,
  localparam int ADDR_W      = addr_w(H_ACTIVE, V_ACTIVE),
  localparam int ENG_W       = eng_w(NUM_ENGINES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [COORD_W-1:0]            cfg_x0,
  input  logic [COORD_W-1:0]            cfg_y0,
  input  logic [COORD_W-1:0]            cfg_step,
  output logic                          busy,
  output logic                          frame_done,
  input  logic [NUM_ENGINES-1:0]        eng_idle,
  output logic                          job_valid,
  output logic [ENG_W-1:0]              job_engine,
  output logic [COORD_W-1:0]            job_re,
  output logic [COORD_W-1:0]            job_im,
  output logic [ADDR_W-1:0]             job_addr,
  input  logic [NUM_ENGINES-1:0]        res_valid,
  input  logic [NUM_ENGINES*ITER_W-1:0] res_iter,
  input  logic [NUM_ENGINES*ADDR_W-1:0] res_addr,
  output logic [NUM_ENGINES-1:0]        res_ack,
  output logic                          fb_we,
  output logic [ADDR_W-1:0]             fb_addr,
  output logic [ITER_W-1:0]             fb_data
);

  localparam int XW = cnt_w(H_ACTIVE);
  localparam int YW = cnt_w(V_ACTIVE + 1);

  state_t                   state;
  logic [COORD_W-1:0]       x0_q, step_q, re_q, im_q;
  logic [XW-1:0]            x_q;
  logic [YW-1:0]            y_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [NUM_ENGINES-1:0]   outstanding;

  logic [NUM_ENGINES-1:0]   eligible, cand, grant, set_mask;
  logic [ENG_W-1:0]         disp_idx, grant_idx;
  logic                     disp_hit, issue, grant_vld, res_en, last_x, last_y;

  assign eligible = eng_idle & ~outstanding;
  assign issue    = (state == ST_DISPATCH) && disp_hit;
  assign last_x   = (x_q == XW'(H_ACTIVE - 1));
  assign last_y   = (y_q == YW'(V_ACTIVE - 1));
  assign res_en   = (state == ST_DISPATCH) || (state == ST_DRAIN);
  // Results from engines we never dispatched to are ignored, not just deprioritised.
  assign cand     = res_en ? (res_valid & outstanding) : '0;
  assign res_ack  = grant;
  assign set_mask = issue ? (NUM_ENGINES'(1) << disp_idx) : '0;

  always_comb begin
    disp_hit = 1'b0;
    disp_idx = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        disp_hit = 1'b1;
        disp_idx = ENG_W'(i);
      end
    end
  end

  mandel_rr_arbiter #(
    .N (NUM_ENGINES),
    .W (ENG_W)
  ) u_res_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (cand),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      job_valid   <= 1'b0;
      job_engine  <= '0;
      job_re      <= '0;
      job_im      <= '0;
      job_addr    <= '0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
      x0_q        <= '0;
      step_q      <= '0;
      re_q        <= '0;
      im_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      outstanding <= '0;
    end else begin
      job_valid   <= 1'b0;
      fb_we       <= 1'b0;
      frame_done  <= 1'b0;
      // Set and clear masks never overlap: grants need outstanding, dispatch needs it clear.
      outstanding <= (outstanding | set_mask) & ~grant;

      if (grant_vld) begin
        fb_we   <= 1'b1;
        fb_addr <= res_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        fb_data <= res_iter[int'(grant_idx)*ITER_W +: ITER_W];
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            x0_q   <= cfg_x0;
            step_q <= cfg_step;
            re_q   <= cfg_x0;
            im_q   <= cfg_y0;
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
            busy   <= 1'b1;
            state  <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (issue) begin
            job_valid  <= 1'b1;
            job_engine <= disp_idx;
            job_re     <= re_q;
            job_im     <= im_q;
            job_addr   <= addr_q;
            addr_q     <= addr_q + ADDR_W'(1);
            if (last_x) begin
              x_q  <= '0;
              re_q <= x0_q;
              y_q  <= y_q + YW'(1);
              im_q <= im_q + step_q;
              if (last_y) state <= ST_DRAIN;
            end else begin
              x_q  <= x_q + XW'(1);
              re_q <= re_q + step_q;
            end
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
